// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers for the
// E stage of a 5-stage MIPS pipeline.
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-low reset
//   Start  in   1   E-stage instruction is mult/multu/div/divu (one-cycle pulse)
//   MDOp   in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 rsvd
//   SrcA   in   32  forwarded rs value
//   SrcB   in   32  forwarded rt value
//   Busy   out  1   registered; computation in flight
//   HI     out  32  registered HI
//   LO     out  32  registered LO
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  logic               start_ok;
  logic               start_mul;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_we;

  assign start_ok  = Start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
  assign start_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);

  // Sign-extended 64x64 product keeps the low 64 bits equal to the signed result.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign sa     = $signed(a_q);
  assign sb     = $signed(b_q);

  // Result selection from the latched operands; divide by zero leaves HI/LO alone.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_we = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_we = 1'b1;
      end
      OP_DIV: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          // Most-negative / -1 overflows; pin the architectural result.
          if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
            res_hi = 32'd0;
            res_lo = 32'h8000_0000;
          end else begin
            res_hi = 32'(sa % sb);
            res_lo = 32'(sa / sb);
          end
        end
      end
      OP_DIVU: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          res_hi = a_q % b_q;
          res_lo = a_q / b_q;
        end
      end
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  // Control FSM, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            op_q    <= MDOp;
            a_q     <= SrcA;
            b_q     <= SrcB;
            cnt_q   <= start_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          end else if (!Start && (MDOp == OP_MTHI)) begin
            hi_q <= SrcA;
          end else if (!Start && (MDOp == OP_MTLO)) begin
            lo_q <= SrcA;
          end
        end
        S_RUN: begin
          // Start/mthi/mtlo are ignored while running.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (res_we) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

`ifdef MDU_HAZARD_ASSERT
  // Enabled at integration, where the hazard unit keeps HI/LO ops away from a busy unit.
  a_no_op_while_busy: assert property (@(posedge clk) disable iff (!rst)
    busy_q |-> !(Start || (MDOp == OP_MTHI) || (MDOp == OP_MTLO)))
    else $error("HI/LO-class op issued while busy");
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: vector table plus hand-written corner sequences,
// expected HI/LO held in a scoreboard queue until Busy falls.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          inj_at;
    logic        inj_start;
    logic [2:0]  inj_op;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .MDOp  (MDOp),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one op at the current negedge; counts Busy cycles and checks the popped result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int cyc,
                        input int inj_at, input logic inj_start, input logic [2:0] inj_op,
                        input string tag);
    int   n;
    exp_t e;
    sb_q.push_back('{hi: hi, lo: lo});
    Start = 1'b1;
    MDOp  = op;
    SrcA  = a;
    SrcB  = b;
    @(negedge clk);
    n = 0;
    while (Busy && n < 200) begin
      if (n == inj_at) begin
        Start = inj_start;
        MDOp  = inj_op;
        SrcA  = 32'hDEAD_BEEF;
      end else begin
        Start = 1'b0;
        MDOp  = 3'd0;
        SrcA  = $urandom;
      end
      SrcB = $urandom;
      @(negedge clk);
      n++;
    end
    Start = 1'b0;
    MDOp  = 3'd0;
    check({tag, "_busy_cycles"}, 32'(n), 32'(cyc));
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, HI, e.hi);
      check({tag, "_lo"}, LO, e.lo);
    end
    m_hi = hi;
    m_lo = lo;
  endtask

  // mthi/mtlo at the current negedge; result visible one edge later, no Busy.
  task automatic do_mt(input logic [2:0] op, input logic [31:0] v, input string tag);
    Start = 1'b0;
    MDOp  = op;
    SrcA  = v;
    @(negedge clk);
    MDOp = 3'd0;
    SrcA = $urandom;
    if (op == 3'd5) m_hi = v;
    else            m_lo = v;
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_hi"}, HI, m_hi);
    check({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    //           op    a             b             hi            lo            cyc inj st    inj_op
    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 5,  -1, 1'b0, 3'd0};
    vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5,  -1, 1'b0, 3'd0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, -1, 1'b0, 3'd0};
    vecs[3]  = '{3'd4, 32'd7,         32'd2,        32'd1,         32'd3,         10, -1, 1'b0, 3'd0};
    vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10, -1, 1'b0, 3'd0};
    vecs[5]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10, -1, 1'b0, 3'd0};
    vecs[6]  = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5, -1, 1'b0, 3'd0};
    vecs[7]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        5,  -1, 1'b0, 3'd0};
    vecs[8]  = '{3'd1, 32'd3,         32'd4,        32'd0,         32'd12,        5,  2,  1'b0, 3'd6};
    vecs[9]  = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        10, 4,  1'b1, 3'd3};
    vecs[10] = '{3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 5,  0,  1'b0, 3'd5};
    vecs[11] = '{3'd3, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFF2, 10, -1, 1'b0, 3'd0};

    rst   = 1'b0;
    Start = 1'b0;
    MDOp  = 3'd0;
    SrcA  = 32'd0;
    SrcB  = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table vectors run back to back: each Start lands the cycle Busy falls.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc,
             vecs[i].inj_at, vecs[i].inj_start, vecs[i].inj_op, $sformatf("vec%0d", i));
    end

    // Start with a non-arithmetic MDOp is ignored, including 5/6 (no mthi/mtlo).
    for (int k = 0; k < 4; k++) begin
      Start = 1'b1;
      MDOp  = (k == 0) ? 3'd0 : (k == 1) ? 3'd5 : (k == 2) ? 3'd6 : 3'd7;
      SrcA  = 32'h5555_5555;
      SrcB  = 32'd3;
      @(negedge clk);
      Start = 1'b0;
      MDOp  = 3'd0;
      check($sformatf("bad_start%0d_busy", k), 32'(Busy), 32'd0);
      check($sformatf("bad_start%0d_hi", k), HI, m_hi);
      check($sformatf("bad_start%0d_lo", k), LO, m_lo);
    end

    // mthi then divide by zero: HI keeps the moved value, LO unchanged.
    do_mt(3'd5, 32'h0000_1234, "mthi");
    run_op(3'd4, 32'd5, 32'd0, m_hi, m_lo, 10, -1, 1'b0, 3'd0, "divu_by_zero");
    do_mt(3'd6, 32'h0000_CAFE, "mtlo");
    run_op(3'd3, 32'hFFFF_FFF0, 32'd0, m_hi, m_lo, 10, -1, 1'b0, 3'd0, "div_by_zero");

    // Async reset three cycles into a divide.
    Start = 1'b1;
    MDOp  = 3'd3;
    SrcA  = 32'd100;
    SrcB  = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    MDOp  = 3'd0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 32'(Busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_reset_busy", 32'(Busy), 32'd0);
    check("mid_reset_hi", HI, 32'd0);
    check("mid_reset_lo", LO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (12) @(negedge clk);
    check("post_reset_busy", 32'(Busy), 32'd0);
    check("post_reset_hi", HI, 32'd0);
    check("post_reset_lo", LO, 32'd0);
    run_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5, -1, 1'b0, 3'd0, "mult_after_reset");

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
